// File: rtl/conv_layer_pkg.sv
// Shared types and fixed-point helper for the conv_layer_core engine.
// DATA_SIZE is limited to MAX_W bits by fx_mul.
package conv_layer_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        EMIT
    } state_t;

    typedef logic [15:0] index_t;

    // Signed full-width product, arithmetic shift by the fractional bits;
    // the caller truncates to its own word width.
    function automatic logic [2*MAX_W-1:0] fx_mul(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b,
        input int                      frac_bits
    );
        logic signed [2*MAX_W-1:0] prod;
        prod = (2*MAX_W)'(a) * (2*MAX_W)'(b);
        return prod >>> frac_bits;
    endfunction

endpackage

// File: rtl/conv_layer_core_mac.sv
// Single-cycle fixed-point multiply/shift/accumulate with clear-on-load.
module conv_mac
    import conv_layer_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int FRAC_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clear,
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    output logic [DATA_SIZE-1:0] acc
);

    logic [DATA_SIZE-1:0] product;
    logic [DATA_SIZE-1:0] acc_reg;

    assign product = DATA_SIZE'(fx_mul(MAX_W'(signed'(a)), MAX_W'(signed'(b)), FRAC_BITS));

    // Clear loads the first product directly so no idle cycle is needed per pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= clear ? product : acc_reg + product;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/conv_layer_core.sv
// Stride-1 valid 2-D convolution layer over internally stored activations/weights.
// Optional CONV_LAYER_RELU_EN clamps negative results to zero.
module conv_layer_core
    import conv_layer_pkg::*;
#(
    parameter string NAME        = "LAYER",
    parameter int    NUM_INPUTS  = 2,
    parameter int    INPUT_DIM   = 5,
    parameter int    NUM_OUTPUTS = 2,
    parameter int    KERNEL_DIM  = 3,
    parameter int    DATA_SIZE   = 64,
    parameter int    FRAC_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 want_write_act,
    input  logic                 want_write_weights,
    input  logic [DATA_SIZE-1:0] write_data,
    input  logic [15:0]          in_index3,
    input  logic [15:0]          in_index2,
    input  logic [15:0]          in_index1,
    input  logic [15:0]          in_index0,
    input  logic                 compute,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [15:0]          out_index [2:0],
    output logic                 output_valid
);

    localparam int     OUT_DIM   = INPUT_DIM - KERNEL_DIM + 1;
    localparam int     ACT_DEPTH = NUM_INPUTS * INPUT_DIM * INPUT_DIM;
    localparam int     W_DEPTH   = NUM_OUTPUTS * NUM_INPUTS * KERNEL_DIM * KERNEL_DIM;
    localparam int     ACT_AW    = $clog2(ACT_DEPTH);
    localparam int     W_AW      = $clog2(W_DEPTH);
    localparam index_t IN_CH     = index_t'(NUM_INPUTS);
    localparam index_t OUT_CH    = index_t'(NUM_OUTPUTS);
    localparam index_t IN_DIM_I  = index_t'(INPUT_DIM);
    localparam index_t K_DIM_I   = index_t'(KERNEL_DIM);
    localparam index_t I_LAST    = index_t'(NUM_INPUTS - 1);
    localparam index_t O_LAST    = index_t'(NUM_OUTPUTS - 1);
    localparam index_t K_LAST    = index_t'(KERNEL_DIM - 1);
    localparam index_t P_LAST    = index_t'(OUT_DIM - 1);
    localparam string  name_unused = NAME;

    logic [DATA_SIZE-1:0] act_mem [ACT_DEPTH];
    logic [DATA_SIZE-1:0] w_mem   [W_DEPTH];

    state_t state_reg, state_next;
    index_t i_reg, kr_reg, kc_reg, o_reg, r_reg, c_reg;
    index_t i_next, kr_next, kc_next, o_next, r_next, c_next;
    logic   mac_en, mac_clear, emit;

    logic                 act_in_range, w_in_range;
    logic [ACT_AW-1:0]    wr_act_addr, rd_act_addr;
    logic [W_AW-1:0]      wr_w_addr, rd_w_addr;
    logic [DATA_SIZE-1:0] mac_acc, result;

    assign act_in_range = (in_index2 < IN_CH) && (in_index1 < IN_DIM_I) && (in_index0 < IN_DIM_I);
    assign w_in_range   = (in_index3 < OUT_CH) && (in_index2 < IN_CH)
                       && (in_index1 < K_DIM_I) && (in_index0 < K_DIM_I);
    assign wr_act_addr  = ACT_AW'((int'(in_index2) * INPUT_DIM + int'(in_index1)) * INPUT_DIM
                                  + int'(in_index0));
    assign wr_w_addr    = W_AW'(((int'(in_index3) * NUM_INPUTS + int'(in_index2)) * KERNEL_DIM
                                 + int'(in_index1)) * KERNEL_DIM + int'(in_index0));

    // Weight strobe has priority: a coincident activation write is dropped.
    always_ff @(posedge clk) begin
        if (state_reg == IDLE) begin
            if (want_write_weights) begin
                if (w_in_range) w_mem[wr_w_addr] <= write_data;
            end else if (want_write_act && act_in_range) begin
                act_mem[wr_act_addr] <= write_data;
            end
        end
    end

    // Reads are combinational so each MAC cycle consumes a fresh operand pair.
    assign rd_act_addr = ACT_AW'((int'(i_reg) * INPUT_DIM + int'(r_reg) + int'(kr_reg)) * INPUT_DIM
                                 + int'(c_reg) + int'(kc_reg));
    assign rd_w_addr   = W_AW'(((int'(o_reg) * NUM_INPUTS + int'(i_reg)) * KERNEL_DIM
                                + int'(kr_reg)) * KERNEL_DIM + int'(kc_reg));

    conv_mac #(
        .DATA_SIZE (DATA_SIZE),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mac_en),
        .clear (mac_clear),
        .a     (act_mem[rd_act_addr]),
        .b     (w_mem[rd_w_addr]),
        .acc   (mac_acc)
    );

    always_comb begin
        result = mac_acc;
`ifdef CONV_LAYER_RELU_EN
        if (mac_acc[DATA_SIZE-1]) result = '0;
`endif
    end

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        kr_next    = kr_reg;
        kc_next    = kc_reg;
        o_next     = o_reg;
        r_next     = r_reg;
        c_next     = c_reg;
        mac_en     = 1'b0;
        mac_clear  = 1'b0;
        emit       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (compute) begin
                    state_next = MAC;
                    i_next  = '0; kr_next = '0; kc_next = '0;
                    o_next  = '0; r_next  = '0; c_next  = '0;
                end
            end
            MAC: begin
                mac_en    = 1'b1;
                mac_clear = (i_reg == '0) && (kr_reg == '0) && (kc_reg == '0);
                if (kc_reg != K_LAST) begin
                    kc_next = kc_reg + index_t'(1);
                end else begin
                    kc_next = '0;
                    if (kr_reg != K_LAST) begin
                        kr_next = kr_reg + index_t'(1);
                    end else begin
                        kr_next = '0;
                        if (i_reg != I_LAST) begin
                            i_next = i_reg + index_t'(1);
                        end else begin
                            i_next     = '0;
                            state_next = EMIT;
                        end
                    end
                end
            end
            EMIT: begin
                emit       = 1'b1;
                state_next = MAC;
                if (c_reg != P_LAST) begin
                    c_next = c_reg + index_t'(1);
                end else begin
                    c_next = '0;
                    if (r_reg != P_LAST) begin
                        r_next = r_reg + index_t'(1);
                    end else begin
                        r_next = '0;
                        if (o_reg != O_LAST) begin
                            o_next = o_reg + index_t'(1);
                        end else begin
                            o_next     = '0;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            i_reg        <= '0;
            kr_reg       <= '0;
            kc_reg       <= '0;
            o_reg        <= '0;
            r_reg        <= '0;
            c_reg        <= '0;
            out_data     <= '0;
            out_index[2] <= '0;
            out_index[1] <= '0;
            out_index[0] <= '0;
            output_valid <= 1'b0;
        end else begin
            state_reg    <= state_next;
            i_reg        <= i_next;
            kr_reg       <= kr_next;
            kc_reg       <= kc_next;
            o_reg        <= o_next;
            r_reg        <= r_next;
            c_reg        <= c_next;
            output_valid <= emit;
            if (emit) begin
                out_data     <= result;
                out_index[2] <= o_reg;
                out_index[1] <= r_reg;
                out_index[0] <= c_reg;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_core.sv
// Directed-vector bench for conv_layer_core at default parameters (1.0 = 0x10000).
module tb_conv_layer_core;

    localparam logic [63:0] ONE     = 64'h1_0000;
    localparam logic [63:0] NEG_ONE = 64'hFFFF_FFFF_FFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        want_write_act, want_write_weights, compute;
    logic [63:0] write_data;
    logic [15:0] in_index3, in_index2, in_index1, in_index0;
    logic [63:0] out_data;
    logic [15:0] out_index [2:0];
    logic        output_valid;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q [18];
    logic [63:0] neg_exp;

    conv_layer_core #(.NAME("TB_LAYER")) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .want_write_act     (want_write_act),
        .want_write_weights (want_write_weights),
        .write_data         (write_data),
        .in_index3          (in_index3),
        .in_index2          (in_index2),
        .in_index1          (in_index1),
        .in_index0          (in_index0),
        .compute            (compute),
        .out_data           (out_data),
        .out_index          (out_index),
        .output_valid       (output_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: sim time limit reached, bench stuck");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic wr(input logic act, input logic wt, input int i3, input int i2,
                      input int i1, input int i0, input logic [63:0] d);
        want_write_act     = act;
        want_write_weights = wt;
        in_index3 = 16'(i3); in_index2 = 16'(i2); in_index1 = 16'(i1); in_index0 = 16'(i0);
        write_data = d;
        @(negedge clk);
        want_write_act     = 1'b0;
        want_write_weights = 1'b0;
    endtask

    task automatic fill_acts(input logic [63:0] v);
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) wr(1'b1, 1'b0, 0, i, r, c, v);
    endtask

    task automatic fill_weights(input logic [63:0] v);
        for (int o = 0; o < 2; o++)
            for (int i = 0; i < 2; i++)
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++) wr(1'b0, 1'b1, o, i, kr, kc, v);
    endtask

    // Pulses compute and checks every valid pulse; inj = cycle of mid-run
    // writes/compute, rst_at = cycle of reset abort (0 disables either).
    task automatic do_run(input string name, input int inj, input int rst_at, input int exp_pulses);
        int   pulses;
        logic aborted;
        pulses  = 0;
        aborted = 1'b0;
        compute = 1'b1;
        @(negedge clk);
        compute = 1'b0;
        for (int cyc = 1; cyc <= 400 && pulses < 18; cyc++) begin
            if (cyc == inj) begin
                compute = 1'b1;
                want_write_act = 1'b1;
                in_index3 = 16'd0; in_index2 = 16'd0; in_index1 = 16'd0; in_index0 = 16'd0;
                write_data = 64'h5_0000;
            end
            if (cyc == inj + 1 && inj != 0) begin
                want_write_weights = 1'b1;
                in_index3 = 16'd1; in_index2 = 16'd0; in_index1 = 16'd0; in_index0 = 16'd0;
                write_data = ONE;
            end
            if (cyc == rst_at) rst_n = 1'b0;
            @(negedge clk);
            compute = 1'b0;
            want_write_act = 1'b0;
            want_write_weights = 1'b0;
            rst_n = 1'b1;
            if (cyc == rst_at) begin
                aborted = 1'b1;
                check_vec({name, " rst_valid"}, 64'(output_valid), 64'd0);
                check_vec({name, " rst_data"}, out_data, 64'd0);
                check_vec({name, " rst_idx"}, {16'd0, out_index[2], out_index[1], out_index[0]}, 64'd0);
            end else if (output_valid) begin
                if (aborted) begin
                    check_vec({name, " post_rst_valid"}, 64'd1, 64'd0);
                end else begin
                    check_vec($sformatf("%s px%0d data", name, pulses), out_data, exp_q[pulses]);
                    check_vec($sformatf("%s px%0d idx", name, pulses),
                              {16'd0, out_index[2], out_index[1], out_index[0]},
                              {16'd0, 16'(pulses / 9), 16'((pulses / 3) % 3), 16'(pulses % 3)});
                    check_vec($sformatf("%s px%0d cycle", name, pulses), 64'(cyc), 64'(19 * (pulses + 1)));
                end
                pulses++;
            end
        end
        check_vec({name, " pulses"}, 64'(pulses), 64'(exp_pulses));
        if (exp_pulses == 18) begin
            @(negedge clk);
            check_vec({name, " idle_valid"}, 64'(output_valid), 64'd0);
            check_vec({name, " hold_data"}, out_data, exp_q[17]);
        end
    endtask

    initial begin
`ifdef CONV_LAYER_RELU_EN
        neg_exp = 64'd0;
`else
        neg_exp = NEG_ONE;
`endif
        rst_n = 1'b0;
        want_write_act = 1'b0; want_write_weights = 1'b0; compute = 1'b0;
        write_data = '0;
        in_index3 = '0; in_index2 = '0; in_index1 = '0; in_index0 = '0;
        repeat (3) @(negedge clk);
        check_vec("reset valid", 64'(output_valid), 64'd0);
        check_vec("reset data", out_data, 64'd0);
        check_vec("reset idx", {16'd0, out_index[2], out_index[1], out_index[0]}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All ones: every pixel sums 18 taps of 1.0.
        fill_acts(ONE);
        fill_weights(ONE);
        for (int k = 0; k < 18; k++) exp_q[k] = 64'h12_0000;
        do_run("ones", 0, 0, 18);

        // Ramp on channel 0, single centre weight 2.0 for output channel 1.
        fill_acts(64'd0);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) wr(1'b1, 1'b0, 0, 0, r, c, 64'((5 * r + c) * 65536));
        fill_weights(64'd0);
        wr(1'b0, 1'b1, 1, 0, 1, 1, 64'h2_0000);
        for (int k = 0; k < 18; k++)
            exp_q[k] = (k < 9) ? 64'd0 : 64'(2 * (5 * ((k / 3) % 3 + 1) + (k % 3) + 1) * 65536);
        do_run("ramp", 0, 0, 18);

        // Out-of-range writes dropped, in_index3 ignored for acts, weight wins a collision.
        wr(1'b1, 1'b0, 0, 0, 0, 7, 64'h4D_0000);
        wr(1'b0, 1'b1, 0, 0, 0, 3, 64'h5_0000);
        wr(1'b1, 1'b0, 9, 1, 3, 3, 64'h3_0000);
        wr(1'b1, 1'b1, 0, 1, 1, 1, ONE);
        for (int k = 0; k < 9; k++) exp_q[k] = 64'd0;
        exp_q[8] = 64'h3_0000;
        do_run("bounds", 0, 0, 18);

        // Single negative weight on channel 0.
        fill_acts(ONE);
        fill_weights(64'd0);
        wr(1'b0, 1'b1, 0, 0, 0, 0, NEG_ONE);
        for (int k = 0; k < 18; k++) exp_q[k] = (k < 9) ? neg_exp : 64'd0;
        do_run("neg", 0, 0, 18);

        // Writes and a second compute while busy must be ignored.
        do_run("midrun", 50, 0, 18);

        // Reset abort at cycle 100, then rerun from retained memories.
        do_run("abort", 0, 100, 5);
        @(negedge clk);
        do_run("rerun", 0, 0, 18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
